fp_op_sequencer: RTL and testbench

Single-issue scheduler that sits between the FP front end and the two FP execution units: the add/sub datapath (`add_sub_top`, combinational) and the multi-cycle Newton divider (`fdiv_newton`, busy handshake). It does four things:
- accepts one operation at a time on a valid/ready request port;
- routes it to the correct unit and drives that unit's handshake;
- guards the divider with a timeout;
- returns result, error code and tag on a valid/ready response port.

---
 rtl/fp_op_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fp_op_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_op_sequencer.sv
// Single-issue scheduler between the FP front end, the add/sub datapath and the Newton divider.
// Optional FP_SEQ_PERF_EN adds latency reporting on rsp_cycles and per-opcode completion counters.
module fp_op_sequencer #(
  parameter int EXP_BITS    = 8,
  parameter int SIG_BITS    = 23,
  parameter int TAG_BITS    = 4,
  parameter int DIV_TIMEOUT = 31,
  localparam int W          = EXP_BITS + SIG_BITS + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_opc,
  input  logic [W-1:0]        req_a,
  input  logic [W-1:0]        req_b,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic [W-1:0]        as_a,
  output logic [W-1:0]        as_b,
  output logic                as_opcode,
  input  logic [W-1:0]        as_result,
  input  logic [2:0]          as_err,
  output logic                div_ena,
  output logic                div_fdiv,
  output logic [W-1:0]        div_a,
  output logic [W-1:0]        div_b,
  input  logic [W-1:0]        div_s,
  input  logic                div_busy,
  input  logic [2:0]          div_err,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_result,
  output logic [2:0]          rsp_err,
  output logic [TAG_BITS-1:0] rsp_tag,
  output logic [7:0]          rsp_cycles
);

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} opcode_t;
  typedef enum logic [2:0] {IDLE, AS_EXEC, DIV_START, DIV_ARM, DIV_WAIT, RESP} state_t;

  localparam int TW = (DIV_TIMEOUT < 2) ? 1 : $clog2(DIV_TIMEOUT + 1);
  localparam logic [2:0] ERR_UNSUP   = 3'b110;
  localparam logic [2:0] ERR_TIMEOUT = 3'b111;

  state_t        state, state_d;
  opcode_t       opc_in;
  logic [TW-1:0] cnt;
  logic          tmo;

  assign opc_in    = opcode_t'(req_opc);
  assign tmo       = (cnt >= TW'(DIV_TIMEOUT));
  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  // Handshake lines decode straight from state so a reset drops them without waiting for an edge.
  assign div_fdiv  = (state == DIV_START);
  assign div_ena   = (state == DIV_START) || (state == DIV_ARM) || (state == DIV_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (req_valid) begin
        case (opc_in)
          OP_ADD, OP_SUB: state_d = AS_EXEC;
          OP_MUL:         state_d = RESP;
          default:        state_d = DIV_START;
        endcase
      end
      AS_EXEC:   state_d = RESP;
      DIV_START: state_d = DIV_ARM;
      DIV_ARM:   if (tmo) state_d = RESP;
                 else if (div_busy) state_d = DIV_WAIT;
      // Completion is tested first so it wins over a coincident timeout.
      DIV_WAIT:  if (!div_busy || tmo) state_d = RESP;
      RESP:      if (rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      as_a       <= '0;
      as_b       <= '0;
      as_opcode  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      rsp_result <= '0;
      rsp_err    <= '0;
      rsp_tag    <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rsp_tag <= req_tag;
          cnt     <= '0;
          case (opc_in)
            OP_ADD, OP_SUB: begin
              as_a      <= req_a;
              as_b      <= req_b;
              as_opcode <= req_opc[0];
            end
            OP_MUL: begin
              rsp_result <= '0;
              rsp_err    <= ERR_UNSUP;
            end
            default: begin
              div_a <= req_a;
              div_b <= req_b;
            end
          endcase
        end
        AS_EXEC: begin
          rsp_result <= as_result;
          rsp_err    <= as_err;
        end
        DIV_START: cnt <= cnt + TW'(1);
        DIV_ARM: begin
          if (tmo) begin
            rsp_result <= '0;
            rsp_err    <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        DIV_WAIT: begin
          if (!div_busy) begin
            rsp_result <= div_s;
            rsp_err    <= div_err;
          end else if (tmo) begin
            rsp_result <= '0;
            rsp_err    <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FP_SEQ_PERF_EN
  logic [7:0]       pc;
  opcode_t          op_q;
  logic [3:0][15:0] op_done;

  assign rsp_cycles = pc;

  // pc is 1 after the accept edge and stops advancing once RESP is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      op_q    <= OP_ADD;
      op_done <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          pc   <= 8'd1;
          op_q <= opc_in;
        end
        RESP: if (rsp_ready && op_done[op_q] != 16'hFFFF)
          op_done[op_q] <= op_done[op_q] + 16'd1;
        default: pc <= (pc == 8'hFF) ? pc : pc + 8'd1;
      endcase
    end
  end
`else
  assign rsp_cycles = '0;
`endif

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer with a small add/sub lookup model and a busy-handshake divider model.
module tb_fp_op_sequencer;
  localparam int W = 32;
`ifdef FP_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [1:0]    req_opc = '0;
  logic [W-1:0]  req_a = '0, req_b = '0;
  logic [3:0]    req_tag = '0;
  logic [W-1:0]  as_a, as_b, as_result;
  logic          as_opcode;
  logic [2:0]    as_err;
  logic          div_ena, div_fdiv, div_busy;
  logic [W-1:0]  div_a, div_b, div_s;
  logic [2:0]    div_err;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0]  rsp_result;
  logic [2:0]    rsp_err;
  logic [3:0]    rsp_tag;
  logic [7:0]    rsp_cycles;

  int n_chk = 0, n_fail = 0;
  int div_len = 19;
  bit div_stuck = 1'b0;
  int rem;

  fp_op_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .as_a(as_a), .as_b(as_b),
    .as_opcode(as_opcode), .as_result(as_result), .as_err(as_err), .div_ena(div_ena),
    .div_fdiv(div_fdiv), .div_a(div_a), .div_b(div_b), .div_s(div_s), .div_busy(div_busy),
    .div_err(div_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag), .rsp_cycles(rsp_cycles)
  );

  always #5 clk = ~clk;

  // Add/sub model only knows the two vectors used; anything else gives a poison value.
  always_comb begin
    if (!as_opcode && as_a == 32'h3F800000 && as_b == 32'h40000000) begin
      as_result = 32'h40400000; as_err = 3'b000;
    end else if (as_opcode && as_a == 32'h40400000 && as_b == 32'h3F800000) begin
      as_result = 32'h40000000; as_err = 3'b000;
    end else begin
      as_result = 32'hDEADBEEF; as_err = 3'b001;
    end
    div_s   = (div_a == 32'h40C00000 && div_b == 32'h40400000) ? 32'h40000000 : 32'hBAD0BAD0;
    div_err = 3'b000;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0; rem <= 0;
    end else if (div_fdiv) begin
      div_busy <= 1'b1; rem <= div_len;
    end else if (div_busy && !div_stuck) begin
      if (rem == 0) div_busy <= 1'b0;
      else rem <= rem - 1;
    end
  end

  task automatic send(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] tag);
    @(negedge clk);
    req_valid = 1'b1; req_opc = opc; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0; req_opc = '0;
  endtask

  // Waits (bounded) for rsp_valid; returns number of negedges seen after the accept edge.
  task automatic wait_rsp(input int limit, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < limit && !ok) begin
      @(negedge clk); n++;
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL handshake: rsp_valid=%b req_ready=%b, need 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({req_ready, rsp_valid, div_ena, div_fdiv, as_opcode} !== 5'b0 ||
        as_a !== '0 || div_a !== '0 || rsp_result !== '0 || rsp_err !== '0 || rsp_tag !== '0 ||
        rsp_cycles !== '0) begin
      n_fail++; $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b div_ena=%b as_a=%h rsp=%h",
                         req_ready, rsp_valid, div_ena, as_a, rsp_result);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b need 1", req_ready);
    end
  endtask

  task automatic test_add();
    int n; bit ok;
    send(2'd0, 32'h3F800000, 32'h40000000, 4'd5);
    wait_rsp(10, n, ok);
    n_chk++;
    if (!ok || n !== 2) begin
      n_fail++; $display("FAIL add_latency: rsp_valid after %0d negedges (ok=%b) need 2", n, ok);
    end
    n_chk++;
    if (rsp_result !== 32'h40400000 || rsp_err !== 3'b000 || rsp_tag !== 4'd5) begin
      n_fail++; $display("FAIL add_result: got %h/%b/%0d need 40400000/000/5", rsp_result, rsp_err, rsp_tag);
    end
    n_chk++;
    if (rsp_cycles !== (PERF ? 8'd2 : 8'd0)) begin
      n_fail++; $display("FAIL add_cycles: got %0d need %0d", rsp_cycles, PERF ? 2 : 0);
    end
    handshake();
  endtask

  task automatic test_div();
    int n = 0, fdiv_cnt = 0, first_fdiv = -1, rdy_bad = 0;
    bit ok = 1'b0;
    div_len = 19;
    send(2'd3, 32'h40C00000, 32'h40400000, 4'd7);
    while (n < 100 && !ok) begin
      @(negedge clk); n++;
      if (div_fdiv) begin fdiv_cnt++; if (first_fdiv < 0) first_fdiv = n; end
      if (req_ready) rdy_bad++;
      if (rsp_valid) ok = 1'b1;
    end
    n_chk++;
    if (fdiv_cnt !== 1 || first_fdiv !== 1) begin
      n_fail++; $display("FAIL div_fdiv_pulse: %0d cycles high, first at %0d, need 1 at 1", fdiv_cnt, first_fdiv);
    end
    n_chk++;
    if (!ok || rdy_bad !== 0) begin
      n_fail++; $display("FAIL div_ready_low: ok=%b req_ready high %0d cycles, need 0", ok, rdy_bad);
    end
    n_chk++;
    if (rsp_result !== 32'h40000000 || rsp_err !== 3'b000 || rsp_tag !== 4'd7 || div_ena !== 1'b0) begin
      n_fail++; $display("FAIL div_result: got %h/%b/%0d ena=%b need 40000000/000/7 ena=0",
                         rsp_result, rsp_err, rsp_tag, div_ena);
    end
    handshake();
  endtask

  task automatic test_mul();
    int n = 0, fdiv_seen = 0;
    bit ok = 1'b0;
    logic [W-1:0] a0, b0;
    a0 = as_a; b0 = as_b;
    send(2'd2, 32'h40000000, 32'h40400000, 4'd3);
    while (n < 10 && !ok) begin
      @(negedge clk); n++;
      if (div_fdiv) fdiv_seen++;
      if (rsp_valid) ok = 1'b1;
    end
    n_chk++;
    if (!ok || n !== 1) begin
      n_fail++; $display("FAIL mul_latency: rsp_valid after %0d negedges (ok=%b) need 1", n, ok);
    end
    n_chk++;
    if (rsp_err !== 3'b110 || rsp_result !== '0 || rsp_tag !== 4'd3) begin
      n_fail++; $display("FAIL mul_unsupported: got %h/%b/%0d need 0/110/3", rsp_result, rsp_err, rsp_tag);
    end
    n_chk++;
    if (fdiv_seen !== 0 || as_a !== a0 || as_b !== b0) begin
      n_fail++; $display("FAIL mul_side_effects: fdiv=%0d as_a=%h as_b=%h need 0 %h %h", fdiv_seen, as_a, as_b, a0, b0);
    end
    n_chk++;
    if (rsp_cycles !== (PERF ? 8'd1 : 8'd0)) begin
      n_fail++; $display("FAIL mul_cycles: got %0d need %0d", rsp_cycles, PERF ? 1 : 0);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int n; bit ok;
    div_stuck = 1'b1;
    send(2'd3, 32'h40C00000, 32'h40400000, 4'd2);
    wait_rsp(100, n, ok);
    // fdiv cycle is counter 0; 31 more cycles expire the budget, plus the accept-to-start cycle
    n_chk++;
    if (!ok || n < 32 || n > 34) begin
      n_fail++; $display("FAIL timeout_latency: rsp_valid after %0d negedges (ok=%b) need 32..34", n, ok);
    end
    n_chk++;
    if (rsp_err !== 3'b111 || rsp_result !== '0 || div_ena !== 1'b0 || rsp_tag !== 4'd2) begin
      n_fail++; $display("FAIL timeout_result: got %h/%b ena=%b tag=%0d need 0/111 ena=0 tag=2",
                         rsp_result, rsp_err, div_ena, rsp_tag);
    end
    div_stuck = 1'b0;
    handshake();
    send(2'd1, 32'h40400000, 32'h3F800000, 4'd9);
    wait_rsp(10, n, ok);
    n_chk++;
    if (!ok || n !== 2 || rsp_result !== 32'h40000000 || rsp_err !== 3'b000 || rsp_tag !== 4'd9) begin
      n_fail++; $display("FAIL sub_after_timeout: n=%0d got %h/%b/%0d need 2 40000000/000/9",
                         n, rsp_result, rsp_err, rsp_tag);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int n, unstable = 0; bit ok;
    logic [W-1:0] r0; logic [2:0] e0; logic [3:0] t0;
    send(2'd0, 32'h3F800000, 32'h40000000, 4'd12);
    wait_rsp(10, n, ok);
    r0 = rsp_result; e0 = rsp_err; t0 = rsp_tag;
    n_chk++;
    if (!ok || r0 !== 32'h40400000 || t0 !== 4'd12) begin
      n_fail++; $display("FAIL bp_first: ok=%b got %h/%0d need 40400000/12", ok, r0, t0);
    end
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_result !== r0 || rsp_err !== e0 || rsp_tag !== t0) unstable++;
    end
    n_chk++;
    if (unstable !== 0) begin
      n_fail++; $display("FAIL bp_stable: %0d unstable cycles, need 0", unstable);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    div_len = 19;
    send(2'd3, 32'h40C00000, 32'h40400000, 4'd4);
    repeat (5) @(negedge clk);
    n_chk++;
    if (div_ena !== 1'b1 || div_busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: div_ena=%b div_busy=%b need 1/1", div_ena, div_busy);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({div_ena, div_fdiv, rsp_valid, req_ready} !== 4'b0 || div_a !== '0 || as_a !== '0 ||
        rsp_result !== '0 || rsp_tag !== '0) begin
      n_fail++; $display("FAIL rstmid_async: ena=%b fdiv=%b valid=%b ready=%b div_a=%h as_a=%h need all 0",
                         div_ena, div_fdiv, rsp_valid, req_ready, div_a, as_a);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_no_rsp: rsp_valid=%b req_ready=%b need 0/1", rsp_valid, req_ready);
    end
    send(2'd0, 32'h3F800000, 32'h40000000, 4'd6);
    wait_rsp(10, n, ok);
    n_chk++;
    if (!ok || n !== 2 || rsp_result !== 32'h40400000 || rsp_err !== 3'b000 || rsp_tag !== 4'd6) begin
      n_fail++; $display("FAIL rstmid_add: n=%0d got %h/%b/%0d need 2 40400000/000/6",
                         n, rsp_result, rsp_err, rsp_tag);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_mul();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
